// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and EHXPLLL phase-select/direction constants for pll_phase_ctrl.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        IDLE,
        SETUP,
        STEP,
        HOLD
    } state_t;

    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;
    localparam logic [1:0] SEL_CLKOP  = 2'b11;

    localparam logic DIR_ADV = 1'b0;
    localparam logic DIR_DLY = 1'b1;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser bringing the asynchronous PLL LOCK into the reference clock domain.
module sync2_ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL sequencer: PLL reset, lock supervision, sys_rst generation and phase-step serialisation.
// Define PLL_PHASE_ACC_EN to build the per-output phase accumulators; otherwise phase_acc reads 0.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYC      = 16,
    parameter int LOCK_WAIT    = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int SETUP_CYC    = 2,
    parameter int STEP_CYC     = 2,
    parameter int HOLD_CYC     = 2,
    parameter int STEP_W       = 8,
    parameter int ACC_W        = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 pll_lock,
    output logic                 pll_rst,
    output logic [1:0]           pll_phasesel,
    output logic                 pll_phasedir,
    output logic                 pll_phasestep,
    output logic                 sys_rst,
    output logic                 locked,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_sel,
    input  logic                 req_dir,
    input  logic [STEP_W-1:0]    req_steps,
    output logic                 busy,
    output logic [7:0]           relock_cnt,
    output logic [4*ACC_W-1:0]   phase_acc
);

    localparam int SEQ_MAX = RST_CYC + SETUP_CYC + STEP_CYC + HOLD_CYC;
    localparam int CNT_W   = $clog2(SEQ_MAX + 1);
    localparam int STAB_W  = $clog2(LOCK_WAIT + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

    // SETUP loads SETUP_CYC (not -1): its first cycle drives sel/dir, then SETUP_CYC stable cycles follow.
    localparam logic [CNT_W-1:0]  RST_LOAD   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0]  STEP_LOAD  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_WAIT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t              state;
    logic                lk;
    logic                lost;
    logic [CNT_W-1:0]    seq_cnt;
    logic [STAB_W-1:0]   stab_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [1:0]          lat_sel;
    logic                lat_dir;
    logic [STEP_W-1:0]   remaining;

`ifdef PLL_PHASE_ACC_EN
    logic [ACC_W-1:0]    acc [4];
    assign phase_acc = {acc[3], acc[2], acc[1], acc[0]};
`else
    assign phase_acc = '0;
`endif

    sync2_ff u_lock_sync (
        .clk (CLK),
        .d   (pll_lock),
        .q   (lk)
    );

    always_comb begin
        lost = 1'b0;
        if (!lk && (state == IDLE || state == SETUP || state == STEP || state == HOLD))
            lost = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= RESET;
            seq_cnt       <= RST_LOAD;
            stab_cnt      <= '0;
            tmo_cnt       <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            locked        <= 1'b0;
            req_ready     <= 1'b0;
            busy          <= 1'b0;
            pll_phasestep <= 1'b0;
            pll_phasesel  <= SEL_CLKOS;
            pll_phasedir  <= DIR_ADV;
            relock_cnt    <= '0;
`ifdef PLL_PHASE_ACC_EN
            for (int i = 0; i < 4; i++) acc[i] <= '0;
`endif
        end else if (lost) begin
            // Lock loss wins over everything, including a request offered this cycle.
            state         <= RESET;
            seq_cnt       <= RST_LOAD;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            locked        <= 1'b0;
            req_ready     <= 1'b0;
            busy          <= 1'b0;
            pll_phasestep <= 1'b0;
            relock_cnt    <= sat_inc(relock_cnt);
`ifdef PLL_PHASE_ACC_EN
            for (int i = 0; i < 4; i++) acc[i] <= '0;
`endif
        end else begin
            case (state)
                RESET: begin
                    if (seq_cnt == '0) begin
                        state    <= WAIT_LOCK;
                        pll_rst  <= 1'b0;
                        stab_cnt <= '0;
                        tmo_cnt  <= '0;
                    end else begin
                        seq_cnt <= seq_cnt - CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lk && stab_cnt == STAB_LAST) begin
                        state     <= IDLE;
                        sys_rst   <= 1'b0;
                        locked    <= 1'b1;
                        req_ready <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= RESET;
                        seq_cnt    <= RST_LOAD;
                        pll_rst    <= 1'b1;
                        relock_cnt <= sat_inc(relock_cnt);
                    end else begin
                        stab_cnt <= lk ? stab_cnt + STAB_W'(1) : '0;
                        tmo_cnt  <= tmo_cnt + TMO_W'(1);
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_sel   <= req_sel;
                        lat_dir   <= req_dir;
                        remaining <= req_steps;
                        if (req_steps != '0) begin
                            state     <= SETUP;
                            seq_cnt   <= SETUP_LOAD;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    pll_phasesel <= lat_sel;
                    pll_phasedir <= lat_dir;
                    if (seq_cnt == '0) begin
                        state         <= STEP;
                        pll_phasestep <= 1'b1;
                        seq_cnt       <= STEP_LOAD;
                    end else begin
                        seq_cnt <= seq_cnt - CNT_W'(1);
                    end
                end
                STEP: begin
                    if (seq_cnt == '0) begin
                        state         <= HOLD;
                        pll_phasestep <= 1'b0;
                        seq_cnt       <= HOLD_LOAD;
                        remaining     <= remaining - STEP_W'(1);
`ifdef PLL_PHASE_ACC_EN
                        if (lat_dir == DIR_DLY)
                            acc[lat_sel] <= acc[lat_sel] - ACC_W'(1);
                        else
                            acc[lat_sel] <= acc[lat_sel] + ACC_W'(1);
`endif
                    end else begin
                        seq_cnt <= seq_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (seq_cnt == '0) begin
                        // sel/dir are already settled, so further steps skip SETUP.
                        if (remaining != '0) begin
                            state         <= STEP;
                            pll_phasestep <= 1'b1;
                            seq_cnt       <= STEP_LOAD;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end
                    end else begin
                        seq_cnt <= seq_cnt - CNT_W'(1);
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Controller that sequences an ECP5 EHXPLLL instance on the board:
  - drives the PLL reset;
  - supervises lock and generates the system reset;
  - serialises dynamic phase-shift requests into PHASESEL/PHASEDIR/PHASESTEP waveforms with guaranteed setup and hold.
- Clocked by the free-running reference clock, not a PLL output.
- Sits between the PLL wrapper and the rest of the design, which sees only a clean sys_rst and a phase-request handshake.

Parameters:
- RST_CYC, 16: cycles pll_rst is held high on each (re)start; must be ≥1.
- LOCK_WAIT, 1024: consecutive synced-lock cycles required before releasing sys_rst.
- LOCK_TIMEOUT, 65536: cycles in WAIT_LOCK without completing LOCK_WAIT before restarting the PLL.
- SETUP_CYC, 2: cycles sel/dir are stable before the step pulse.
- STEP_CYC, 2: cycles phasestep is held high.
- HOLD_CYC, 2: cycles after the pulse before the next step or return to idle.
- STEP_W, 8: width of the step-count request.
- ACC_W, 6: width of each per-output phase accumulator.

Ports:
- CLK  in  1  reference clock (25 MHz).
- RST  in  1  synchronous, active-high reset.
- pll_lock  in  1  raw PLL LOCK; asynchronous to CLK.
- pll_rst  out  1  to EHXPLLL RST.
- pll_phasesel  out  2  to PHASESEL1:0. Encoding: 00=CLKOS, 01=CLKOS2, 10=CLKOS3, 11=CLKOP.
- pll_phasedir  out  1  to PHASEDIR. 0=advance, 1=delay.
- pll_phasestep  out  1  to PHASESTEP.
- sys_rst  out  1  active-high reset for downstream logic.
- locked  out  1  lock stable; the inverse of sys_rst.
- req_valid  in  1  phase-shift request.
- req_ready  out  1  controller can accept a request.
- req_sel  in  2  target output.
- req_dir  in  1  direction.
- req_steps  in  STEP_W  number of steps; 0 is legal.
- busy  out  1  a phase shift is in progress.
- relock_cnt  out  8  count of lock losses and timeouts; saturates at 255.
- phase_acc  out  4*ACC_W  per-output accumulated phase, output n at bits [n*ACC_W +: ACC_W].

Behaviour:
- Lock input: pll_lock passes through a 2-FF synchroniser to give lk. Only lk is used internally.
- Reset values (RST high):
  - state = RESET, with the RST_CYC counter loaded;
  - pll_rst=1, sys_rst=1, locked=0, req_ready=0, busy=0;
  - phasestep=0, phasesel=00, phasedir=0;
  - relock_cnt=0, phase_acc=0.
- RESET: pll_rst=1 for RST_CYC cycles, then go to WAIT_LOCK with pll_rst=0.
- WAIT_LOCK:
  - Stable counter increments while lk=1 and clears when lk=0.
  - At LOCK_WAIT: go to IDLE. sys_rst falls on the same edge as the state change.
  - Timeout counter reaching LOCK_TIMEOUT: go to RESET and relock_cnt++.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch sel/dir/steps.
  - steps=0: stay in IDLE; the request is consumed and has no effect.
  - steps>0: go to SETUP; busy=1 from the next cycle.
- SETUP: phasesel and phasedir are driven from the latch. After SETUP_CYC cycles go to STEP.
- STEP: phasestep=1 for STEP_CYC cycles. On exit:
  - remaining steps decrement;
  - phase_acc[sel] += (dir ? -1 : +1), wrapping modulo 2^ACC_W.
- HOLD: phasestep=0 for HOLD_CYC cycles. Then:
  - remaining>0: go to STEP; sel/dir are unchanged, so no new setup is needed;
  - remaining=0: go to IDLE; busy=0.
- phasesel/phasedir hold their last values in IDLE and change only in SETUP.
- Lock loss: lk=0 in IDLE, SETUP, STEP or HOLD causes, on the next edge:
  - state=RESET, sys_rst=1, phasestep=0, busy=0, relock_cnt++;
  - any outstanding steps are discarded;
  - phase_acc is cleared, because the PLL restart resets the phase.
- Simultaneous events: lock loss takes priority over a request accepted in the same cycle, and that request is dropped.
- Latency: req accepted at edge t gives the first phasestep rise at t+1+SETUP_CYC.
- Mid-operation RST: the sequence aborts immediately and all values return to reset values.

Optional Feature:
- Macro: PLL_PHASE_ACC_EN.
- Defined: phase_acc accumulators are implemented as described.
- Undefined: no accumulator registers exist, phase_acc is tied to 0, and all other behaviour is identical.

Decomposition:
- Package pll_ctrl_pkg holds:
  - state enum (RESET, WAIT_LOCK, IDLE, SETUP, STEP, HOLD);
  - phasesel encoding constants SEL_CLKOS/SEL_CLKOS2/SEL_CLKOS3/SEL_CLKOP;
  - DIR_ADV/DIR_DLY constants.
- One sub-module, sync2_ff: the 2-FF synchroniser for pll_lock.

Test Plan:
- Reset, then hold pll_lock=1 from cycle 20 → pll_rst high for 16 cycles; sys_rst falls exactly 1024 + 2 (sync) cycles after lock is seen; req_ready=1.
- pll_lock never asserts → after 65536 cycles in WAIT_LOCK, pll_rst re-pulses and relock_cnt=1.
- Request sel=01, dir=0, steps=3 → phasesel=01 two cycles before each pulse; three 2-cycle phasestep pulses each separated by 2 low cycles; phase_acc[1]=3; busy low after the last HOLD.
- Request sel=10, dir=1, steps=1 from acc=0 (PLL_PHASE_ACC_EN defined) → phase_acc[2]=63 (wrap).
- Drop pll_lock during the second STEP of a 5-step request → within 3 cycles sys_rst=1, phasestep=0, busy=0, relock_cnt increments, accumulators cleared.
- req_valid with steps=0 → no phasestep activity, req_ready stays 1, busy stays 0.
